// File: rtl/bfcpu_pkg.sv
// Shared bfcpu microcode constants, types and loader state encoding.
package bfcpu_pkg;

  localparam int UCODE_DEPTH  = 64;
  localparam int UCODE_ADDR_W = 6;
  localparam int UCODE_WORD_W = 16;

  typedef logic [UCODE_WORD_W-1:0] ucode_word_t;
  typedef logic [UCODE_ADDR_W-1:0] ucode_addr_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LO   = 3'd1,
    HI   = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4,
    CSUM = 3'd5
  } loader_state_t;

  // Byte that makes the mod-256 sum of a whole image come out to zero.
  function automatic logic [7:0] csum_expect(input logic [7:0] sum);
    return (~sum) + 8'd1;
  endfunction

endpackage

// File: rtl/ucode_loader_if.sv
// Write port from the microcode loader into the ucode storage array.
interface ucode_loader_if #(
  parameter int ADDR_W = 6,
  parameter int WORD_W = 16
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/pin_sync_edge.sv
// Synchronizes an asynchronous pin and emits a registered one-cycle pulse per rising edge.
module pin_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic pulse
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin};
      last_q <= sync_q[STAGES-1];
      pulse  <= sync_q[STAGES-1] & ~last_q;
    end
  end

endmodule

// File: rtl/ucode_loader.sv
// Fills the microcode store from byte-wide pin strobes, low byte first.
// Optional image checksum byte enabled by defining UCODE_LOAD_CHECKSUM_EN.
module ucode_loader
  import bfcpu_pkg::*;
#(
  parameter int DEPTH       = UCODE_DEPTH,
  parameter int ADDR_W      = UCODE_ADDR_W,
  parameter int WORD_W      = UCODE_WORD_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            byte_in,
  input  logic                  byte_strobe,
  input  logic                  load_start,
  ucode_loader_if.master        wr,
  output logic                  busy,
  output logic                  load_done,
  output logic                  err
);

  logic [1:0]        rst_sync_q;
  logic              rst_int_n;
  logic              strobe_edge;

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic              pend_q, pend_d;
  logic [7:0]        pbyte_q, pbyte_d;
  logic              byte_evt;
  logic [7:0]        byte_sel;
  logic              last_addr;
`ifdef UCODE_LOAD_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  // Reset asserts immediately, releases two clocks after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  pin_sync_edge #(.STAGES(SYNC_STAGES)) u_strobe (
    .clk   (clk),
    .rst_n (rst_int_n),
    .pin   (byte_strobe),
    .pulse (strobe_edge)
  );

  // A byte that arrived while writing is replayed from pbyte_q.
  assign byte_evt  = strobe_edge | pend_q;
  assign byte_sel  = pend_q ? pbyte_q : byte_in;
  assign last_addr = (addr_q == ADDR_W'(DEPTH - 1));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    pend_d  = 1'b0;
    pbyte_d = pbyte_q;
`ifdef UCODE_LOAD_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    if (load_start) begin
      state_d = LO;
      addr_d  = '0;
      err_d   = 1'b0;
`ifdef UCODE_LOAD_CHECKSUM_EN
      sum_d   = 8'd0;
`endif
    end else begin
      case (state_q)
        IDLE: ;
        LO: if (byte_evt) begin
          data_d[7:0] = byte_sel;
          state_d     = HI;
`ifdef UCODE_LOAD_CHECKSUM_EN
          sum_d       = sum_q + byte_sel;
`endif
        end
        HI: if (byte_evt) begin
          data_d[15:8] = byte_sel;
          state_d      = WR;
`ifdef UCODE_LOAD_CHECKSUM_EN
          sum_d        = sum_q + byte_sel;
`endif
        end
        WR: begin
          pend_d = strobe_edge;
          if (strobe_edge) pbyte_d = byte_in;
          if (last_addr) begin
`ifdef UCODE_LOAD_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
`endif
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = LO;
          end
        end
`ifdef UCODE_LOAD_CHECKSUM_EN
        CSUM: if (byte_evt) begin
          if (byte_sel != csum_expect(sum_q)) err_d = 1'b1;
          state_d = DONE;
        end
`endif
        DONE: if (byte_evt) err_d = 1'b1;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
`ifdef UCODE_LOAD_CHECKSUM_EN
      sum_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
`ifdef UCODE_LOAD_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    pbyte_q <= pbyte_d;
  end

  assign wr.wr_en   = (state_q == WR);
  assign wr.wr_addr = addr_q;
  assign wr.wr_data = data_q;
`ifdef UCODE_LOAD_CHECKSUM_EN
  assign busy       = (state_q == LO) || (state_q == HI) || (state_q == WR) || (state_q == CSUM);
`else
  assign busy       = (state_q == LO) || (state_q == HI) || (state_q == WR);
`endif
  assign load_done  = (state_q == DONE);
  assign err        = err_q;

endmodule

// File: tb/tb_ucode_loader.sv
// Directed bench for ucode_loader with a write scoreboard; honours UCODE_LOAD_CHECKSUM_EN.
module tb_ucode_loader;
  localparam int SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] byte_in = 8'h00;
  logic       byte_strobe = 1'b0;
  logic       load_start = 1'b0;
  logic       busy, load_done, err;

  int n_vec = 0;
  int n_bad = 0;
  int wr_cnt = 0;
  logic [31:0] exp_q[$];

  ucode_loader_if #(.ADDR_W(6), .WORD_W(16)) wr_bus ();

  ucode_loader #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .byte_in     (byte_in),
    .byte_strobe (byte_strobe),
    .load_start  (load_start),
    .wr          (wr_bus.master),
    .busy        (busy),
    .load_done   (load_done),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every write pulse must match the oldest pushed expectation.
  always @(negedge clk) begin
    if (wr_bus.wr_en === 1'b1) begin
      logic [31:0] e;
      wr_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {10'd0, wr_bus.wr_addr, wr_bus.wr_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr_data", {10'd0, wr_bus.wr_addr, wr_bus.wr_data}, e);
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk) load_start = 1'b1;
    @(negedge clk) load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    byte_in     = b;
    byte_strobe = 1'b1;
    repeat (3) @(negedge clk);
    byte_strobe = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_word(input logic [5:0] a, input logic [15:0] w);
    exp_q.push_back({10'd0, a, w});
    send_byte(w[7:0]);
    send_byte(w[15:8]);
  endtask

  task automatic full_load(input bit bad_cks);
    logic [7:0] sum;
    int c0;
    sum = 8'd0;
    c0  = wr_cnt;
    pulse_start();
    chk("full_busy_after_start", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 64; k++) begin
      send_word(6'(k), 16'(16'h0100 * k + k));
      sum = sum + 8'(k) + 8'(k);
    end
    chk("full_write_count", wr_cnt - c0, 32'd64);
    chk("full_queue_empty", exp_q.size(), 32'd0);
`ifdef UCODE_LOAD_CHECKSUM_EN
    chk("cks_no_done_before_byte", {31'd0, load_done}, 32'd0);
    send_byte(bad_cks ? ((~sum) + 8'd2) : ((~sum) + 8'd1));
    chk("cks_err", {31'd0, err}, {31'd0, bad_cks});
`else
    chk("full_err", {31'd0, err}, 32'd0);
`endif
    chk("full_load_done", {31'd0, load_done}, 32'd1);
    chk("full_busy_clear", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int c0;
    // Reset state
    #3 rst_n = 1'b0;
    #1;
    chk("rst_wr_en", {31'd0, wr_bus.wr_en}, 32'd0);
    chk("rst_outputs", {10'd0, wr_bus.wr_addr, wr_bus.wr_data}, 32'd0);
    chk("rst_flags", {29'd0, busy, load_done, err}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Strobes before load_start are ignored
    send_byte(8'hAA);
    send_byte(8'hBB);
    chk("idle_ignored_writes", wr_cnt, 32'd0);
    chk("idle_flags", {29'd0, busy, load_done, err}, 32'd0);

    // Byte order and latency
    pulse_start();
    send_byte(8'h34);
    exp_q.push_back({10'd0, 6'd0, 16'h1234});
    @(negedge clk);
    byte_in     = 8'h12;
    byte_strobe = 1'b1;
    for (int i = 1; i <= SYNC_STAGES + 1; i++) begin
      @(posedge clk); #1;
      chk("latency_no_early_wr", {31'd0, wr_bus.wr_en}, 32'd0);
    end
    @(posedge clk); #1;
    chk("latency_wr_en", {31'd0, wr_bus.wr_en}, 32'd1);
    chk("byte_order_data", {10'd0, wr_bus.wr_addr, wr_bus.wr_data}, {10'd0, 6'd0, 16'h1234});
    @(posedge clk); #1;
    chk("wr_en_single_cycle", {31'd0, wr_bus.wr_en}, 32'd0);
    repeat (2) @(negedge clk);
    byte_strobe = 1'b0;
    repeat (4) @(negedge clk);

    // Restart mid-word discards the stale low byte
    pulse_start();
    for (int k = 0; k < 5; k++) send_word(6'(k), 16'hA000 + 16'(k));
    send_byte(8'h77);
    pulse_start();
    chk("restart_addr", {26'd0, wr_bus.wr_addr}, 32'd0);
    send_word(6'd0, 16'hC35A);

    // load_start coincident with a strobe edge drops the byte
    @(negedge clk);
    byte_in     = 8'h99;
    byte_strobe = 1'b1;
    repeat (3) @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    byte_strobe = 1'b0;
    repeat (4) @(negedge clk);
    chk("coincident_busy", {31'd0, busy}, 32'd1);
    send_word(6'd0, 16'h2211);
    chk("restart_queue_empty", exp_q.size(), 32'd0);

    // Full load, then overrun
    full_load(1'b0);
    c0 = wr_cnt;
    send_byte(8'hEE);
    chk("overrun_err", {31'd0, err}, 32'd1);
    chk("overrun_no_write", wr_cnt - c0, 32'd0);
    chk("overrun_done_held", {31'd0, load_done}, 32'd1);
    pulse_start();
    chk("restart_clears", {29'd0, busy, load_done, err}, 32'b100);

    // Asynchronous reset mid-word
    send_byte(8'h55);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", {10'd0, wr_bus.wr_addr, wr_bus.wr_data}, 32'd0);
    chk("async_rst_flags", {28'd0, wr_bus.wr_en, busy, load_done, err}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    c0 = wr_cnt;
    send_byte(8'h01);
    send_byte(8'h02);
    chk("post_rst_ignored", wr_cnt - c0, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

`ifdef UCODE_LOAD_CHECKSUM_EN
    full_load(1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
